pwm_gen: RTL and testbench

Registered PWM generator that sits directly downstream of the free-running up-counter. It consumes the counter's `count` value and produces a pulse-width-modulated output aligned to counter wrap. Duty-cycle updates arrive over a valid/ready handshake and are double-buffered, so they take effect only at a period boundary. This guarantees glitch-free waveforms.

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_if.sv | 11 +
 rtl/pwm_duty_buf.sv | 57 +++++
 rtl/pwm_gen.sv | 79 +++++++
 tb/tb_pwm_gen.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM generator: FSM state encoding and
// the saturation applied to incoming duty requests.
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } pwm_state_t;

  // Clamp a requested duty to the full-period value 2^width.
  function automatic logic [31:0] sat_duty(input logic [31:0] duty, input int unsigned width);
    logic [31:0] max_duty;
    max_duty = 32'd1 << width;
    return (duty > max_duty) ? max_duty : duty;
  endfunction

endpackage

// File: rtl/pwm_if.sv
// Duty-cycle update channel: a WIDTH+1 bit duty value offered over valid/ready.
interface pwm_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH:0] duty;
  logic           duty_valid;
  logic           duty_ready;

  modport master (output duty, output duty_valid, input duty_ready);
  modport slave  (input duty, input duty_valid, output duty_ready);
endinterface

// File: rtl/pwm_duty_buf.sv
// Double buffer for the duty value: a one-deep pending slot filled over
// valid/ready and an active register that only changes on promote.
module pwm_duty_buf
  import pwm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [WIDTH:0] duty_in,
  input  logic           duty_valid,
  output logic           duty_ready,
  input  logic           promote,
  output logic [WIDTH:0] active_duty
);

  logic [WIDTH:0] active_q, active_d;
  logic [WIDTH:0] pend_q, pend_d;
  logic           pend_full_q, pend_full_d;
  logic           capture;
  logic           do_promote;

  assign duty_ready = !pend_full_q && !rst;
  assign capture    = duty_valid && duty_ready;
  assign do_promote = promote && pend_full_q;

  // Capture and promotion are exclusive because ready is low while full,
  // so a freshly captured value can never bypass straight into active.
  always_comb begin
    active_d    = active_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (do_promote) begin
      active_d    = pend_q;
      pend_full_d = 1'b0;
    end else if (capture) begin
      pend_d      = (WIDTH+1)'(sat_duty(32'(duty_in), WIDTH));
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else begin
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
    end
  end

  // Duty in effect this cycle, including a same-cycle promotion.
  assign active_duty = active_d;

endmodule

// File: rtl/pwm_gen.sv
// PWM generator aligned to an upstream free-running counter: FSM, period
// boundary detection and the registered compare against the active duty.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] count,
  pwm_if.slave             duty_bus,
  output logic             pwm_out,
  output logic             period_start
);

  pwm_state_t     state_q, state_d;
  logic [WIDTH-1:0] prev_count_q, prev_count_d;
  logic           pwm_out_q, pwm_out_d;
  logic           period_start_q, period_start_d;
  logic           boundary;
  logic [WIDTH:0] duty_eff;
  logic           duty_ready_w;

  pwm_duty_buf #(.WIDTH(WIDTH)) u_duty_buf (
    .clk        (clk),
    .rst        (rst),
    .duty_in    (duty_bus.duty),
    .duty_valid (duty_bus.duty_valid),
    .duty_ready (duty_ready_w),
    .promote    (boundary),
    .active_duty(duty_eff)
  );

  assign duty_bus.duty_ready = duty_ready_w;

  // A counter stalled at zero must yield one boundary only, hence the
  // previous-count qualifier in RUN; ARM just waits for the first zero.
  always_comb begin
    state_d  = state_q;
    boundary = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM: begin
          if (count == '0) begin
            state_d  = ST_RUN;
            boundary = 1'b1;
          end
        end
        ST_RUN:  boundary = (count == '0) && (prev_count_q != '0);
        default: state_d = ST_IDLE;
      endcase
    end
    pwm_out_d      = (state_d == ST_RUN) && ({1'b0, count} < duty_eff);
    period_start_d = boundary;
    prev_count_d   = count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      prev_count_q   <= '0;
      pwm_out_q      <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_count_q   <= prev_count_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
    end
  end

  assign pwm_out      = pwm_out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen at WIDTH=4: expected outputs are queued when each
// count is driven and popped once the registered outputs are visible.
module tb_pwm_gen;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [W-1:0] count;
  logic         pwm_out;
  logic         period_start;

  pwm_if #(.WIDTH(W)) bus ();

  pwm_gen #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .count       (count),
    .duty_bus    (bus),
    .pwm_out     (pwm_out),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pwm;
    logic ps;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive count/enable, queue the expected registered outputs,
  // then compare one time unit after the edge. Duty offers are one-shot.
  task automatic cyc(input int c, input logic en, input logic ep, input logic es);
    exp_t e;
    count  = c[W-1:0];
    enable = en;
    e.pwm  = ep;
    e.ps   = es;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    $display("[TB] count=%0d en=%0b dv=%0b pwm=%0b/%0b ps=%0b/%0b rdy=%0b",
             c, en, bus.duty_valid, pwm_out, e.pwm, period_start, e.ps, bus.duty_ready);
    check($sformatf("pwm_out count=%0d", c), {7'd0, pwm_out}, {7'd0, e.pwm});
    check($sformatf("period_start count=%0d", c), {7'd0, period_start}, {7'd0, e.ps});
    bus.duty_valid = 1'b0;
  endtask

  // A full running period 0..15 with expected active duty dexp; optionally
  // offers offer_val at count offer_at (negative means no offer).
  task automatic period(input int dexp, input int offer_at, input int offer_val);
    for (int c = 0; c < 16; c++) begin
      if (c == offer_at) begin
        bus.duty       = offer_val[W:0];
        bus.duty_valid = 1'b1;
      end
      cyc(c, 1'b1, c < dexp, c == 0);
      if (c == 0)
        check("ready_after_boundary", {7'd0, bus.duty_ready}, 8'd1);
      if (offer_at >= 0 && (c == offer_at || c == 15))
        check($sformatf("ready_low_pending count=%0d", c), {7'd0, bus.duty_ready}, 8'd0);
    end
  endtask

  initial begin
    rst            = 1'b1;
    enable         = 1'b0;
    count          = '0;
    bus.duty       = 5'd9;
    bus.duty_valid = 1'b1;

    // Reset with an offer pending: nothing may be captured.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_pwm_out", {7'd0, pwm_out}, 8'd0);
      check("rst_period_start", {7'd0, period_start}, 8'd0);
      check("rst_duty_ready", {7'd0, bus.duty_ready}, 8'd0);
    end
    rst            = 1'b0;
    bus.duty_valid = 1'b0;
    #1;
    check("ready_after_rst", {7'd0, bus.duty_ready}, 8'd1);

    // Load duty 4 while idle, then enable with the counter at 5.
    bus.duty       = 5'd4;
    bus.duty_valid = 1'b1;
    cyc(4, 1'b0, 1'b0, 1'b0);
    check("ready_after_capture", {7'd0, bus.duty_ready}, 8'd0);
    for (int c = 5; c < 16; c++) cyc(c, 1'b1, 1'b0, 1'b0);
    period(4, -1, 0);
    period(4, -1, 0);

    // Mid-period update to 12, then extremes and saturation.
    period(4, 7, 12);
    period(12, 3, 0);
    period(0, -1, 0);
    period(0, -1, 0);
    period(0, 5, 16);
    period(16, 5, 20);
    period(16, 2, 8);
    period(8, 10, 3);

    // Counter stalled at 0: one boundary, one promotion.
    cyc(0, 1'b1, 1'b1, 1'b1);
    check("stall_ready_after_promote", {7'd0, bus.duty_ready}, 8'd1);
    bus.duty       = 5'd6;
    bus.duty_valid = 1'b1;
    cyc(0, 1'b1, 1'b1, 1'b0);
    check("stall_capture_no_promote", {7'd0, bus.duty_ready}, 8'd0);
    for (int i = 0; i < 3; i++) cyc(0, 1'b1, 1'b1, 1'b0);
    check("stall_pending_kept", {7'd0, bus.duty_ready}, 8'd0);
    for (int c = 1; c < 16; c++) cyc(c, 1'b1, c < 3, 1'b0);
    period(6, 4, 8);

    // Enable drop at count 2, re-enable at count 9.
    cyc(0, 1'b1, 1'b1, 1'b1);
    cyc(1, 1'b1, 1'b1, 1'b0);
    for (int c = 2; c < 9; c++) cyc(c, 1'b0, 1'b0, 1'b0);
    for (int c = 9; c < 16; c++) cyc(c, 1'b1, 1'b0, 1'b0);
    period(8, 6, 5);

    // Enable falling in a boundary cycle with pending full: no promotion.
    cyc(0, 1'b0, 1'b0, 1'b0);
    check("disable_boundary_no_promote", {7'd0, bus.duty_ready}, 8'd0);
    for (int c = 1; c < 16; c++) cyc(c, 1'b1, 1'b0, 1'b0);
    period(5, 9, 2);

    // Reset mid-operation discards pending and clears active.
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_pwm_out", {7'd0, pwm_out}, 8'd0);
    check("midrst_period_start", {7'd0, period_start}, 8'd0);
    check("midrst_duty_ready", {7'd0, bus.duty_ready}, 8'd0);
    rst = 1'b0;
    #1;
    check("midrst_pending_dropped", {7'd0, bus.duty_ready}, 8'd1);
    for (int c = 1; c < 16; c++) cyc(c, 1'b1, 1'b0, 1'b0);
    period(0, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
